// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage stall vector, redirect flush and EX watchdog.
// Optional PIPE_CTRL_PERF_EN builds the saturating stall cycle counter; otherwise stall_cnt is 0.
module pipe_ctrl #(
   parameter int          STALL_W = 6,
   parameter int          TIMEOUT = 64,
   parameter logic [31:0] TRAP_PC = 32'h0000_0040,
   parameter int          CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stallreq_id,
   input  logic               stallreq_ex,
   input  logic               flush_req,
   input  logic [31:0]        flush_pc,
   output logic [STALL_W-1:0] stall,
   output logic               flush,
   output logic [31:0]        new_pc,
   output logic               timeout,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [STALL_W-1:0] STALL_EX  = STALL_W'(6'b001111);
   localparam logic [STALL_W-1:0] STALL_ID  = STALL_W'(6'b000111);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_EX_WAIT = 2'd1,
      ST_FLUSH   = 2'd2
   } state_t;

   state_t              state_r, state_nxt_s;
   logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
   logic [31:0]         new_pc_r, new_pc_nxt_s;
   logic                timeout_r, timeout_nxt_s;
   logic                flush_r;
   logic [STALL_W-1:0]  stall_s;

   // Stall vector; requests seen during FLUSH belong to squashed instructions.
   always_comb begin
      stall_s = {STALL_W{1'b0}};
      if (!rst) begin
         stall_s = {STALL_W{1'b0}};
      end else if (state_r == ST_FLUSH) begin
         stall_s = {STALL_W{1'b0}};
      end else if (flush_req) begin
         stall_s = {STALL_W{1'b0}};
      end else if (stallreq_ex) begin
         stall_s = STALL_EX;
      end else if (stallreq_id) begin
         stall_s = STALL_ID;
      end else begin
         stall_s = {STALL_W{1'b0}};
      end
   end

   // Next-state, watchdog count and redirect target selection.
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      new_pc_nxt_s   = new_pc_r;
      timeout_nxt_s  = timeout_r;
      case (state_r)
         ST_RUN: begin
            if (flush_req) begin
               state_nxt_s  = ST_FLUSH;
               new_pc_nxt_s = flush_pc;
            end else if (stallreq_ex) begin
               state_nxt_s    = ST_EX_WAIT;
               wait_cnt_nxt_s = WAIT_W'(1);
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_EX_WAIT: begin
            // A real redirect outranks a watchdog expiring in the same cycle.
            if (flush_req) begin
               state_nxt_s    = ST_FLUSH;
               new_pc_nxt_s   = flush_pc;
               wait_cnt_nxt_s = {WAIT_W{1'b0}};
            end else if (!stallreq_ex) begin
               state_nxt_s    = ST_RUN;
               wait_cnt_nxt_s = {WAIT_W{1'b0}};
            end else if (wait_cnt_r == WAIT_LAST) begin
               state_nxt_s    = ST_FLUSH;
               new_pc_nxt_s   = TRAP_PC;
               timeout_nxt_s  = 1'b1;
               wait_cnt_nxt_s = {WAIT_W{1'b0}};
            end else begin
               wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
            end
         end
         ST_FLUSH: begin
            if (flush_req) begin
               state_nxt_s  = ST_FLUSH;
               new_pc_nxt_s = flush_pc;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: begin
            state_nxt_s    = ST_RUN;
            wait_cnt_nxt_s = {WAIT_W{1'b0}};
         end
      endcase
   end

   // Controller state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_RUN;
         wait_cnt_r <= {WAIT_W{1'b0}};
         new_pc_r   <= 32'h0000_0000;
         timeout_r  <= 1'b0;
         flush_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
         new_pc_r   <= new_pc_nxt_s;
         timeout_r  <= timeout_nxt_s;
         flush_r    <= (state_nxt_s == ST_FLUSH);
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_r;

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if ((|stall_s) && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt = stall_cnt_r;
`else
   assign stall_cnt = {CNT_W{1'b0}};
`endif

   assign stall   = stall_s;
   assign flush   = flush_r;
   assign new_pc  = new_pc_r;
   assign timeout = timeout_r;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage integer core: pc_reg → if_id → id → id_ex → ex → ex_mem → mem → mem_wb → regfile writeback.
- Collects hazard and busy requests from ID and EX, plus redirect requests from MEM.
- Produces the per-stage stall vector, a one-cycle flush pulse with redirect PC, and a watchdog for hung multi-cycle EX operations.

Parameters:
- STALL_W, 6, stall vector width; fixed stage order below.
- TIMEOUT, 64, maximum consecutive EX-busy cycles before the watchdog fires (≥2).
- TRAP_PC, 32'h00000040, redirect target on watchdog timeout.
- CNT_W, 32, stall performance counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- stallreq_id  in  1  load-use hazard from id.
- stallreq_ex  in  1  multi-cycle EX operation busy.
- flush_req  in  1  redirect/exception request from the MEM stage.
- flush_pc  in  32  redirect target, valid with flush_req.
- stall  out  STALL_W  hold controls: bit0 pc_reg, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 reserved (always 0).
- flush  out  1  registered; clear all pipeline registers, load new_pc into pc_reg.
- new_pc  out  32  registered redirect target, valid while flush=1.
- timeout  out  1  sticky watchdog flag.
- stall_cnt  out  CNT_W  saturating count of cycles with stall≠0.

Behaviour:
- Reset (asynchronous, immediate):
  - state=RUN, wait_cnt=0.
  - flush=0, new_pc=0, timeout=0, stall_cnt=0.
  - stall is forced to 0 while rst==0.
- Reset mid-operation aborts any wait or flush with no residual pulse.
- States: RUN, EX_WAIT, FLUSH.
- stall is combinational from state and current inputs. Priority: FLUSH state > flush_req > stallreq_ex > stallreq_id.
  - State FLUSH: stall=0; all requests are ignored, because they come from flushed instructions.
  - flush_req=1 (in RUN or EX_WAIT): stall=0.
  - Otherwise stallreq_ex=1: stall=6'b001111 (pc, if_id, id_ex, ex_mem held; bubble into MEM).
  - Otherwise stallreq_id=1: stall=6'b000111 (bubble into EX).
  - Otherwise stall=0.
- RUN transitions:
  - flush_req → FLUSH; latch new_pc←flush_pc.
  - Else stallreq_ex → EX_WAIT; wait_cnt←1.
  - Else stay in RUN.
- EX_WAIT transitions:
  - flush_req → FLUSH with new_pc←flush_pc; wait_cnt←0; timeout unchanged. flush_req wins over a same-cycle timeout.
  - Else stallreq_ex=0 → RUN; wait_cnt←0. stall drops in the same cycle stallreq_ex falls.
  - Else wait_cnt==TIMEOUT-1 → FLUSH with new_pc←TRAP_PC; timeout←1.
  - Else wait_cnt increments.
- FLUSH timing and transitions:
  - flush=1 for exactly the cycles spent in FLUSH.
  - flush_req in cycle N gives flush=1 in cycle N+1.
  - Exit to RUN when flush_req=0; flush falls next cycle and new_pc holds its last value.
  - flush_req=1 while in FLUSH: stay in FLUSH, re-latch new_pc←flush_pc, flush stays high. Back-to-back redirects take the newest target.
- timeout is cleared only by reset.
- stall_cnt:
  - Increments on each cycle in which stall≠0, sampled at the edge.
  - Saturates at all-ones and does not wrap.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: stall_cnt operates as described above.
- Undefined: the counter register is not built and stall_cnt is tied to 0; all other behaviour is identical.

Test Plan:
- Reset: rst=0 with stallreq_ex=1 → stall=0, flush=0, timeout=0. Release rst → stall=6'b001111 in the same cycle.
- Load-use: stallreq_id=1 for 2 cycles → stall=6'b000111 for exactly those 2 cycles. With PIPE_CTRL_PERF_EN, stall_cnt=2.
- EX busy then redirect: stallreq_ex=1 for 5 cycles with flush_req=1, flush_pc=32'h00001000 in the 3rd cycle → stall=6'b001111 for 2 cycles, stall=0 in the 3rd cycle, flush=1 and new_pc=32'h00001000 for 1 cycle, timeout=0, stallreq_ex ignored during FLUSH.
- Watchdog: TIMEOUT=4, stallreq_ex held high → 4 stalled cycles, then flush=1 with new_pc=32'h00000040, timeout=1 (stays 1 until reset).
- Back-to-back redirect: flush_req high for 2 cycles with targets 32'h100, 32'h200 → flush high for 2 cycles, new_pc=32'h100 then 32'h200, then flush=0.
- Saturation: CNT_W=3, stall held for 10 cycles → stall_cnt=7. Compiled without PIPE_CTRL_PERF_EN → stall_cnt=0 throughout.
